// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a small show-ahead byte FIFO.
//
// Optional build macro UART_RX_PARITY_EN: adds an even-parity bit after the
// data bits and a sticky parity_err output. Without it the receiver is 8N1.
//
// Ports:
//   clock      core clock, rising edge
//   resetb     asynchronous active-low reset
//   rx         serial input, idle high, asynchronous to clock
//   rd_en      pop the head byte (ignored while the FIFO is empty)
//   err_clr    clears the sticky error flags
//   rd_data    head byte of the FIFO; holds the last value once drained
//   rx_valid   FIFO not empty
//   fifo_full  FIFO holds FIFO_DEPTH bytes
//   frame_err  sticky: a stop bit was sampled low
//   overrun    sticky: a byte was dropped because the FIFO was full
//   irq        level interrupt, same as rx_valid
//   parity_err sticky parity mismatch (UART_RX_PARITY_EN builds only)
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       err_clr,
  output logic [7:0] rd_data,
  output logic       rx_valid,
  output logic       fifo_full,
  output logic       frame_err,
  output logic       overrun,
  output logic       irq
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int          PW   = $clog2(FIFO_DEPTH);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // ---------------- input synchroniser (idle-high preset) ----------------
  logic rx_meta, rx_s;
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // ---------------- receive FSM ----------------
  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg, shreg_n;
  logic        push_pend, push_n;
  logic        ferr_set;
  logic        expire;
`ifdef UART_RX_PARITY_EN
  logic        par_bad, par_bad_n;
  logic        perr_set;
`endif

  assign expire = (cnt == 16'd0);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    push_n    = 1'b0;
    ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
    perr_set  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          cnt_n   = HALF;
          state_n = START;
        end
      end
      START: begin
        if (!expire) cnt_n = cnt - 16'd1;
        else if (rx_s) state_n = IDLE;  // start bit vanished: glitch
        else begin
          cnt_n     = FULL;
          bit_idx_n = 3'd0;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (!expire) cnt_n = cnt - 16'd1;
        else begin
          shreg_n   = {rx_s, shreg[7:1]};
          cnt_n     = FULL;
          bit_idx_n = bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state_n = PARITY;
`else
          if (bit_idx == 3'd7) state_n = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!expire) cnt_n = cnt - 16'd1;
        else begin
          // even parity: data plus parity bit must hold an even count of ones
          par_bad_n = ^{shreg, rx_s};
          cnt_n     = FULL;
          state_n   = STOP;
        end
      end
`endif
      STOP: begin
        if (!expire) cnt_n = cnt - 16'd1;
        else begin
          // back to IDLE immediately; a low line here is seen as a new start
          state_n = IDLE;
`ifdef UART_RX_PARITY_EN
          perr_set = par_bad;
          push_n   = rx_s & ~par_bad;
`else
          push_n   = rx_s;
`endif
          ferr_set = ~rx_s;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state     <= IDLE;
      cnt       <= 16'd0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      push_pend <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      push_pend <= push_n;
`ifdef UART_RX_PARITY_EN
      par_bad   <= par_bad_n;
`endif
    end
  end

  // ---------------- FIFO ----------------
  // shreg is stable for a full bit time after STOP, so it is the push data.
  logic [FIFO_DEPTH-1:0][7:0] mem;
  logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [PW:0]   count;
  logic          pop, full, do_push, ovr_set;

  assign full     = (count == (PW+1)'(FIFO_DEPTH));
  assign pop      = rd_en && (count != '0);
  assign do_push  = push_pend && (!full || pop);
  assign ovr_set  = push_pend && full && !pop;
  assign rd_nxt   = rd_ptr + 1'b1;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= 8'h00;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_nxt;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // rd_data is a registered copy of the head; it only moves when the
      // head changes, so it keeps the last byte once the FIFO drains.
      if (pop) begin
        if (count > (PW+1)'(1)) rd_data <= mem[rd_nxt];
        else if (do_push)       rd_data <= shreg;
      end else if (do_push && count == '0) begin
        rd_data <= shreg;
      end
    end
  end

  // ---------------- sticky flags (set wins over clear) ----------------
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= ferr_set | (frame_err & ~err_clr);
      overrun   <= ovr_set  | (overrun   & ~err_clr);
`ifdef UART_RX_PARITY_EN
      parity_err <= perr_set | (parity_err & ~err_clr);
`endif
    end
  end

  assign rx_valid  = (count != '0);
  assign fifo_full = full;
  assign irq       = rx_valid;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
User-project UART receiver for 8N1 serial frames arriving on mprj_io[5]; it consumes the serial stream driven by the testbench UART transmitter (tx_data/tx_start path) during firmware runs.
- Deserialises each frame and stores complete bytes in a small FIFO.
- Firmware drains the FIFO via a simple read strobe.
- Raises a level interrupt while data is pending, so the CPU can service UART interrupts mid-workload (e.g. during qsort).

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (40 MHz core clock / 92160 baud); legal range 8..65535.
FIFO_DEPTH, 4, byte entries in the receive FIFO; power of two, 2..16.

Ports:
clock  input  1  core clock, rising edge.
resetb  input  1  asynchronous active-low reset.
rx  input  1  serial input, idle high, asynchronous to clock.
rd_en  input  1  pop one byte; ignored when rx_valid=0.
err_clr  input  1  clears frame_err and overrun.
rd_data  output  8  byte at FIFO head (show-ahead).
rx_valid  output  1  FIFO not empty.
fifo_full  output  1  FIFO holds FIFO_DEPTH bytes.
frame_err  output  1  sticky: a stop bit was sampled low.
overrun  output  1  sticky: a byte was dropped because the FIFO was full.
irq  output  1  equals rx_valid (level interrupt).

Behaviour:
- Reset: async assert on resetb=0; synchroniser flops preset to 1.
  - All outputs reset to 0; FIFO pointers and count = 0; state = IDLE; rd_data = 0x00.
- Input path: rx passes through a 2-flop synchroniser (rx_s). All sampling uses rx_s.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: on rx_s = 0, load baud counter = CLKS_PER_BIT/2 - 1 (integer division) and go to START.
  - START: count down to 0, then sample rx_s.
    - rx_s = 1: glitch; return to IDLE with no side effects.
    - rx_s = 0: reload counter = CLKS_PER_BIT - 1, bit index = 0, go to DATA.
  - DATA: at each counter expiry, shift rx_s in LSB-first and reload the counter. After bit index 7 is sampled, go to STOP (or PARITY).
  - STOP: at counter expiry, sample rx_s.
    - rx_s = 1: push the byte.
    - rx_s = 0: set frame_err, discard the byte.
    - Either way, return to IDLE in the same cycle. No wait for the line to go high; the next falling edge is detected from IDLE.
- Push timing: the byte is written on the clock edge following the stop-bit sample. rx_valid rises on that edge.
- Latency: falling edge of rx → rx_valid high = 9.5·CLKS_PER_BIT + 3 cycles, ±1.
- FIFO read: rd_data always shows the head entry.
  - rd_en with rx_valid = 1 advances the head on that edge.
  - rd_en with rx_valid = 0 has no effect; rd_data holds its last value.
- Full: a push while full and without a simultaneous pop drops the incoming byte and sets overrun. FIFO contents are unchanged.
- Simultaneous push + pop: both take effect and count is unchanged. When full, the pop frees the slot, so there is no overrun.
- Empty: a pop with no push is ignored.
- Pointers: log2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH. Count is one bit wider.
- Sticky flags: cleared by err_clr. If set and err_clr occur in the same cycle, set wins.
- Reset mid-frame: the partial byte is lost, the FIFO is emptied and the FSM returns to IDLE.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - PARITY state inserted between DATA and STOP; samples one even-parity bit.
  - Extra output parity_err (1 bit, sticky, reset 0, cleared by err_clr).
  - On parity mismatch the byte is discarded at STOP and parity_err is set. frame_err is still evaluated independently.
  - Latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state, no parity_err port, 8N1 only.

Test Plan:
- Bench sends 0x3D at CLKS_PER_BIT = 434 → rx_valid = 1, irq = 1, rd_data = 0x3D within 4126 ± 3 cycles of start edge; one rd_en pulse → rx_valid = 0.
- Send 0x0F then 0x3D back-to-back → two entries; reads yield 0x0F then 0x3D; frame_err = 0.
- Drive rx low for 100 cycles, then high → no push, FSM back in IDLE; next valid frame 0xA5 is received correctly.
- Frame 0x55 with stop bit forced 0 → frame_err = 1, rx_valid stays 0; err_clr → frame_err = 0.
- Send 0x01..0x05 with no reads (depth 4) → fifo_full = 1, overrun = 1; reads return 0x01, 0x02, 0x03, 0x04, then rx_valid = 0. Repeat with rd_en pulsed on the 5th byte's push edge → all five bytes received, overrun = 0.
- Assert resetb = 0 mid-DATA of frame 0x3D → all outputs 0; next frame 0x7E is received cleanly as 0x7E.
